// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Multicycle issue stage in front of an n-bit ALU (ADD/SUB/AND/NOT).
// It fetches the operands from the shared bus one per cycle and holds them
// on the ALU inputs. It captures the ALU output with a zero flag and then
// pulses done.
// Optional feature: define ALU_FWD_EN to let a start with fwd_a=1 reuse the
// previous result as operand A, which skips the bus fetch of A.
module alu_operand_sequencer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   func_in,
  input  logic         fwd_a,
  input  logic [n-1:0] bus_data,
  input  logic         bus_valid,
  output logic [1:0]   bus_req,
  input  logic [n-1:0] alu_out,
  output logic [n-1:0] alu_inp1,
  output logic [n-1:0] alu_inp2,
  output logic [1:0]   alu_func,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] FUNC_NOT = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t       state, state_nxt;
  logic [n-1:0] op_a, op_b, res_q;
  logic [1:0]   func_q;
  logic         zero_q;
  logic         fwd_take;

`ifdef ALU_FWD_EN
  assign fwd_take = fwd_a;
`else
  // Forwarding is compiled out. The port stays for pin compatibility.
  logic unused_fwd_a;
  assign unused_fwd_a = fwd_a;
  assign fwd_take     = 1'b0;
`endif

  // State register. Reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic, plus the control outputs decoded from state.
  always_comb begin
    state_nxt = state;
    bus_req   = 2'b00;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (fwd_take) state_nxt = (func_in == FUNC_NOT) ? EXEC : FETCH_B;
          else          state_nxt = FETCH_A;
        end
      end
      FETCH_A: begin
        bus_req = 2'b01;
        if (bus_valid) state_nxt = (func_q == FUNC_NOT) ? EXEC : FETCH_B;
      end
      FETCH_B: begin
        bus_req = 2'b10;
        if (bus_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, function and result registers. Each one loads only in its own state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a   <= '0;
      op_b   <= '0;
      func_q <= 2'b00;
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          func_q <= func_in;
          if (fwd_take) op_a <= res_q;
        end
        FETCH_A: if (bus_valid) op_a <= bus_data;
        FETCH_B: if (bus_valid) op_b <= bus_data;
        EXEC: begin
          res_q  <= alu_out;
          zero_q <= (alu_out == '0);
        end
        default: ;
      endcase
    end
  end

  assign alu_inp1 = op_a;
  assign alu_inp2 = op_b;
  assign alu_func = func_q;
  assign result   = res_q;
  assign zero     = zero_q;

endmodule
